register_file: RTL

//   Architectural register file directly upstream of the ALU. Provides two combinational

---
 rtl/register_file_pkg.sv | 18 +
 rtl/register_file_if.sv | 25 ++
 rtl/register_file_reg_read_port.sv | 21 ++
 rtl/register_file.sv | 49 ++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared datapath sizing for the register file, ALU, decoder and top level.
package register_file_pkg;

    localparam int DBITS               = 32;
    localparam int REG_INDEX_BIT_WIDTH = 4;
    localparam int NUM_REGS            = 2 ** REG_INDEX_BIT_WIDTH;
    localparam logic [DBITS-1:0] RESET_VALUE = '0;

    typedef logic [DBITS-1:0]               dataT;
    typedef logic [REG_INDEX_BIT_WIDTH-1:0] idxT;
    typedef dataT [NUM_REGS-1:0]            regArrayT;

    // Full-width index equality; every index value addresses a distinct register.
    function automatic logic idxMatch(input idxT a, input idxT b);
        return a == b;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: two read ports, one write port and a debug peek.
interface register_file_if;
    import register_file_pkg::*;

    idxT  rdIdxA;
    idxT  rdIdxB;
    logic wrEn;
    idxT  wrIdx;
    dataT wrData;
    dataT rdDataA;
    dataT rdDataB;
    idxT  dbgIdx;
    dataT dbgData;

    modport master (
        output rdIdxA, rdIdxB, wrEn, wrIdx, wrData, dbgIdx,
        input  rdDataA, rdDataB, dbgData
    );

    modport slave (
        input  rdIdxA, rdIdxB, wrEn, wrIdx, wrData, dbgIdx,
        output rdDataA, rdDataB, dbgData
    );

endinterface

// File: rtl/register_file_reg_read_port.sv
// One combinational read port with write-to-read bypass.
module register_file_reg_read_port
    import register_file_pkg::*;
(
    input  idxT      rdIdx,
    input  regArrayT regs,
    input  logic     wrEn,
    input  idxT      wrIdx,
    input  dataT     wrData,
    output dataT     rdData
);

    // Stored value, replaced by the in-flight write when it targets this index.
    always_comb begin
        rdData = regs[rdIdx];
        if (wrEn && idxMatch(wrIdx, rdIdx)) begin
            rdData = wrData;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file feeding the ALU: two bypassed read ports,
// one synchronous write port, asynchronous clear, and an unbypassed debug peek.
module register_file
    import register_file_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    register_file_if.slave  bus
);

    regArrayT regs;

    idxT  portIdx  [2];
    dataT portData [2];

    assign portIdx[0]  = bus.rdIdxA;
    assign portIdx[1]  = bus.rdIdxB;
    assign bus.rdDataA = portData[0];
    assign bus.rdDataB = portData[1];

    // Storage: reset clears everything immediately and wins over a same-edge write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (bus.wrEn) begin
            regs[bus.wrIdx] <= bus.wrData;
        end
    end

    // Read ports A and B are identical, each bypassing independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gPort
            register_file_reg_read_port uPort (
                .rdIdx  (portIdx[gi]),
                .regs   (regs),
                .wrEn   (bus.wrEn),
                .wrIdx  (bus.wrIdx),
                .wrData (bus.wrData),
                .rdData (portData[gi])
            );
        end
    endgenerate

    // Debug peek shows only what was stored at the last edge.
    assign bus.dbgData = regs[bus.dbgIdx];

endmodule
